// File: rtl/ram5_arbiter.sv
// Round-robin arbiter sharing the ram5 write and read ports between requesters A and B.
// Each accepted transaction takes three cycles: select (IDLE), drive RAM (ACCESS), respond (RESP).
module ram5_arbiter #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          a_gnt,
    output logic          b_gnt,
    output logic          a_rvalid,
    output logic          b_rvalid,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] ram_in_address,
    output logic [DW-1:0] ram_in_data,
    output logic          ram_we,
    output logic [AW-1:0] ram_out_address,
    input  logic [DW-1:0] ram_out_data
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e        state_q, state_d;
    logic          last_q, last_d;    // 1: B was granted last
    logic          owner_q, owner_d;  // 1: B owns the in-flight transaction
    logic          we_q, we_d;
    logic [AW-1:0] in_addr_q, in_addr_d;
    logic [AW-1:0] out_addr_q, out_addr_d;
    logic [DW-1:0] in_data_q, in_data_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic          pick_b;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    // B wins when it is alone, or on a tie when A was granted last.
    assign pick_b    = b_req & (~a_req | ~last_q);
    assign sel_we    = pick_b ? b_we    : a_we;
    assign sel_addr  = pick_b ? b_addr  : a_addr;
    assign sel_wdata = pick_b ? b_wdata : a_wdata;

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        owner_d    = owner_q;
        we_d       = we_q;
        in_addr_d  = in_addr_q;
        in_data_d  = in_data_q;
        out_addr_d = out_addr_q;
        rdata_d    = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (a_req || b_req) begin
                    owner_d = pick_b;
                    last_d  = pick_b;
                    we_d    = sel_we;
                    // RAM address/data registers double as the latched request fields.
                    if (sel_we) begin
                        in_addr_d = sel_addr;
                        in_data_d = sel_wdata;
                    end else begin
                        out_addr_d = sel_addr;
                    end
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (!we_q) rdata_d = ram_out_data;
                state_d = StResp;
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            last_q     <= 1'b1;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            in_addr_q  <= '0;
            in_data_q  <= '0;
            out_addr_q <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            in_addr_q  <= in_addr_d;
            in_data_q  <= in_data_d;
            out_addr_q <= out_addr_d;
            rdata_q    <= rdata_d;
        end
    end

    assign a_gnt           = (state_q == StAccess) && !owner_q;
    assign b_gnt           = (state_q == StAccess) && owner_q;
    assign a_rvalid        = (state_q == StResp) && !we_q && !owner_q;
    assign b_rvalid        = (state_q == StResp) && !we_q && owner_q;
    assign ram_we          = (state_q == StAccess) && we_q;
    assign rdata           = rdata_q;
    assign ram_in_address  = in_addr_q;
    assign ram_in_data     = in_data_q;
    assign ram_out_address = out_addr_q;

endmodule

// File: tb/tb_ram5_arbiter.sv
// Bench for ram5_arbiter: a 32x8 memory stands in for ram5, and a transaction-level
// reference model predicts every output cycle by cycle under directed and random traffic.
module tb_ram5_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [4:0] a_addr = '0, b_addr = '0;
    logic [7:0] a_wdata = '0, b_wdata = '0;
    logic       a_gnt, b_gnt, a_rvalid, b_rvalid, ram_we;
    logic [7:0] rdata, ram_in_data, ram_out_data;
    logic [4:0] ram_in_address, ram_out_address;

    logic [7:0] env_mem [32];
    logic [7:0] ref_mem [32];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: stage of the in-flight transaction (0 none, 1 RAM driven, 2 response).
    int         m_stage = 0;
    bit         m_last_b = 1'b1, m_owner_b, m_we;
    logic [4:0] m_addr;
    logic [7:0] m_wdata;
    bit         e_agnt, e_bgnt, e_arv, e_brv, e_we;
    logic [7:0] e_rdata = '0, e_indata = '0;
    logic [4:0] e_inaddr = '0, e_outaddr = '0;

    bit         glog [$];

    always #5 clk = ~clk;

    assign ram_out_data = env_mem[ram_out_address];

    ram5_arbiter #(.AW(5), .DW(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .a_req           (a_req),
        .a_we            (a_we),
        .a_addr          (a_addr),
        .a_wdata         (a_wdata),
        .b_req           (b_req),
        .b_we            (b_we),
        .b_addr          (b_addr),
        .b_wdata         (b_wdata),
        .a_gnt           (a_gnt),
        .b_gnt           (b_gnt),
        .a_rvalid        (a_rvalid),
        .b_rvalid        (b_rvalid),
        .rdata           (rdata),
        .ram_in_address  (ram_in_address),
        .ram_in_data     (ram_in_data),
        .ram_we          (ram_we),
        .ram_out_address (ram_out_address),
        .ram_out_data    (ram_out_data)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update();
        bit win_b;
        // A write lands in memory at the edge that ends its RAM cycle.
        if (m_stage == 1 && m_we) ref_mem[m_addr] = m_wdata;
        e_agnt = 0; e_bgnt = 0; e_arv = 0; e_brv = 0; e_we = 0;
        if (!rst_n) begin
            m_stage  = 0;
            m_last_b = 1'b1;
            e_rdata  = '0; e_inaddr = '0; e_indata = '0; e_outaddr = '0;
        end else if (m_stage == 0) begin
            if (a_req || b_req) begin
                win_b     = b_req && (!a_req || !m_last_b);
                m_owner_b = win_b;
                m_last_b  = win_b;
                m_we      = win_b ? b_we : a_we;
                m_addr    = win_b ? b_addr : a_addr;
                m_wdata   = win_b ? b_wdata : a_wdata;
                e_agnt    = !win_b;
                e_bgnt    = win_b;
                e_we      = m_we;
                if (m_we) begin
                    e_inaddr = m_addr;
                    e_indata = m_wdata;
                end else begin
                    e_outaddr = m_addr;
                end
                m_stage = 1;
            end
        end else if (m_stage == 1) begin
            if (!m_we) begin
                e_rdata = ref_mem[m_addr];
                e_arv   = !m_owner_b;
                e_brv   = m_owner_b;
            end
            m_stage = 2;
        end else begin
            m_stage = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (ram_we) env_mem[ram_in_address] = ram_in_data;
        model_update();
        #1;
        check_val("a_gnt", a_gnt, e_agnt);
        check_val("b_gnt", b_gnt, e_bgnt);
        check_val("gnt_excl", a_gnt & b_gnt, 0);
        check_val("a_rvalid", a_rvalid, e_arv);
        check_val("b_rvalid", b_rvalid, e_brv);
        check_val("ram_we", ram_we, e_we);
        check_val("rdata", rdata, e_rdata);
        check_val("ram_in_address", ram_in_address, e_inaddr);
        check_val("ram_in_data", ram_in_data, e_indata);
        check_val("ram_out_address", ram_out_address, e_outaddr);
        if (a_gnt) glog.push_back(1'b0);
        if (b_gnt) glog.push_back(1'b1);
    endtask

    task automatic do_reset();
        rst_n = 0; a_req = 0; b_req = 0;
        step();
        rst_n = 1;
    endtask

    initial begin
        int nb;
        for (int i = 0; i < 32; i++) begin
            logic [7:0] v;
            v = 8'($urandom);
            env_mem[i] = v;
            ref_mem[i] = v;
        end

        // Reset held two cycles with A requesting: nothing granted, then A served.
        a_req = 1; a_we = 0; a_addr = 5'd3;
        step();
        step();
        check_val("rst_no_gnt", a_gnt, 0);
        check_val("rst_rdata", rdata, 0);
        rst_n = 1;
        step();
        check_val("first_gnt", a_gnt, 1);
        a_req = 0;
        step();
        check_val("first_rvalid", a_rvalid, 1);
        step();

        // A writes 24 = 45, then B reads it back.
        a_req = 1; a_we = 1; a_addr = 5'd24; a_wdata = 8'd45;
        step();
        check_val("wr_gnt", a_gnt, 1);
        check_val("wr_addr", ram_in_address, 24);
        check_val("wr_data", ram_in_data, 45);
        check_val("wr_we", ram_we, 1);
        a_req = 0;
        step();
        step();
        b_req = 1; b_we = 0; b_addr = 5'd24;
        step();
        b_req = 0;
        step();
        check_val("raw_rvalid", b_rvalid, 1);
        check_val("raw_rdata", rdata, 45);
        step();

        // Simultaneous after reset: A write 4 = 124 first, B read 4 three cycles later.
        do_reset();
        a_req = 1; a_we = 1; a_addr = 5'd4; a_wdata = 8'd124;
        b_req = 1; b_we = 0; b_addr = 5'd4;
        step();
        check_val("tie_a_first", a_gnt, 1);
        a_req = 0;
        step();
        step();
        step();
        check_val("tie_b_gnt", b_gnt, 1);
        b_req = 0;
        step();
        check_val("tie_b_rdata", rdata, 124);
        check_val("tie_b_rvalid", b_rvalid, 1);
        step();

        // Both held: grants alternate A,B,A,B,A,B.
        do_reset();
        glog.delete();
        a_req = 1; a_we = 0; a_addr = 5'd1;
        b_req = 1; b_we = 0; b_addr = 5'd2;
        for (int i = 0; i < 18; i++) step();
        a_req = 0; b_req = 0;
        check_val("alt_count", glog.size(), 6);
        for (int i = 0; i < 6 && i < glog.size(); i++) check_val("alt_order", glog[i], i % 2);
        step();
        step();

        // Reset during A's read access of 14: dropped, then re-served.
        do_reset();
        a_req = 1; a_we = 0; a_addr = 5'd14;
        step();
        check_val("rd14_gnt", a_gnt, 1);
        rst_n = 0;
        step();
        check_val("rd14_dropped", a_rvalid, 0);
        rst_n = 1;
        step();
        check_val("rd14_regnt", a_gnt, 1);
        a_req = 0;
        step();
        check_val("rd14_rvalid", a_rvalid, 1);
        check_val("rd14_rdata", rdata, ref_mem[14]);
        step();

        // B drops its request while A is served: B never granted.
        do_reset();
        a_req = 1; a_we = 1; a_addr = 5'd5; a_wdata = 8'd77;
        b_req = 1; b_we = 0; b_addr = 5'd5;
        step();
        b_req = 0; a_req = 0;
        nb = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (b_gnt) nb++;
        end
        check_val("drop_b_no_gnt", nb, 0);

        // Random traffic with occasional resets and abandoned requests.
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            if (!a_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    a_req = 1; a_we = 1'($urandom_range(0, 1));
                    a_addr = 5'($urandom_range(0, 7)); a_wdata = 8'($urandom);
                end
            end else if (e_agnt) begin
                a_req = 1'($urandom_range(0, 1)); a_we = 1'($urandom_range(0, 1));
                a_addr = 5'($urandom_range(0, 7)); a_wdata = 8'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
                a_req = 0;
            end
            if (!b_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    b_req = 1; b_we = 1'($urandom_range(0, 1));
                    b_addr = 5'($urandom_range(0, 7)); b_wdata = 8'($urandom);
                end
            end else if (e_bgnt) begin
                b_req = 1'($urandom_range(0, 1)); b_we = 1'($urandom_range(0, 1));
                b_addr = 5'($urandom_range(0, 7)); b_wdata = 8'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
                b_req = 0;
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
